// File: rtl/servo_pwm_drive.sv
// Servo PWM driver: captures a requested joint angle, ramps the driven angle toward it
// at a bounded rate once per PWM period, and emits a glitch-free hobby-servo pulse train.
module servo_pwm_drive #(
  parameter int PERIOD_CYC    = 1_000_000,
  parameter int PULSE_MIN_CYC = 25_000,
  parameter int CYC_PER_DEG   = 556,
  parameter int ANGLE_MAX     = 180,
  parameter int STEP_DEG      = 2,
  parameter int INIT_ANGLE    = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] angle_data,
  input  logic       angle_gen_flag,
  input  logic       en,
  output logic       pwm_out,
  output logic [7:0] cur_angle,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int PULSE_MAX = PULSE_MIN_CYC + ANGLE_MAX * CYC_PER_DEG;
  localparam int WID_RAW   = $clog2(PULSE_MAX + 1);
  localparam int WID_A     = (WID_RAW > 20) ? WID_RAW : 20;
  localparam int WID_W     = (WID_A > CNT_W) ? WID_A : CNT_W;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MID     = CNT_W'(PERIOD_CYC / 2);
  localparam logic [7:0]       ANGLE_MAX_8 = 8'(ANGLE_MAX);
  localparam logic [7:0]       STEP_8      = 8'(STEP_DEG);
  localparam logic [7:0]       INIT_8      = 8'(INIT_ANGLE);
  localparam logic [WID_W-1:0] PULSE_MIN_W = WID_W'(PULSE_MIN_CYC);
  localparam logic [WID_W-1:0] CPD_W       = WID_W'(CYC_PER_DEG);
  localparam logic [WID_W-1:0] INIT_WIDTH  = WID_W'(PULSE_MIN_CYC + INIT_ANGLE * CYC_PER_DEG);

  typedef enum logic {HOLD, RAMP} state_t;

  state_t           state_q, state_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       target_q, target_d;
  logic [7:0]       cur_angle_q, cur_angle_d;
  logic [WID_W-1:0] width_q, width_d;
  logic [WID_W-1:0] pulse_len_q, pulse_len_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;

  logic             capture;
  logic             update;
  logic [7:0]       cap_target;
  logic [7:0]       gap;
  logic [7:0]       step;

  // NOTE: every signal assigned here gets a default up front so no path can infer a latch.
  always_comb begin
    flag_d  = angle_gen_flag;
    capture = angle_gen_flag && !flag_q;

    if (angle_data[9]) begin
      cap_target = '0;
    end else if (angle_data > 10'(ANGLE_MAX)) begin
      cap_target = ANGLE_MAX_8;
    end else begin
      cap_target = angle_data[7:0];
    end

    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);

    gap    = (target_q > cur_angle_q) ? target_q - cur_angle_q : cur_angle_q - target_q;
    step   = (gap < STEP_8) ? gap : STEP_8;
    update = (state_q == RAMP) && (cnt_q == CNT_MID);

    state_d     = state_q;
    target_d    = target_q;
    cur_angle_d = cur_angle_q;
    done_d      = 1'b0;

    // The mid-period step always aims at the old target; a coincident capture lands afterwards.
    if (update) begin
      cur_angle_d = (target_q > cur_angle_q) ? cur_angle_q + step : cur_angle_q - step;
      if (cur_angle_d == target_q) begin
        state_d = HOLD;
        done_d  = 1'b1;
      end
    end
    if (capture) begin
      target_d = cap_target;
      state_d  = (cap_target == cur_angle_d) ? HOLD : RAMP;
    end

    width_d     = PULSE_MIN_W + WID_W'(cur_angle_q) * CPD_W;
    pulse_len_d = (cnt_q == CNT_LAST) ? width_q : pulse_len_q;
    pwm_d       = en && (WID_W'(cnt_q) < pulse_len_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HOLD;
      flag_q      <= 1'b0;
      cnt_q       <= '0;
      target_q    <= INIT_8;
      cur_angle_q <= INIT_8;
      width_q     <= INIT_WIDTH;
      pulse_len_q <= INIT_WIDTH;
      pwm_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      cur_angle_q <= cur_angle_d;
      width_q     <= width_d;
      pulse_len_q <= pulse_len_d;
      pwm_q       <= pwm_d;
      done_q      <= done_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign cur_angle = cur_angle_q;
  assign busy      = (state_q == RAMP);
  assign done      = done_q;

endmodule

// File: doc/servo_pwm_drive.md
# servo_pwm_drive

Converts the per-frame rotation angle produced by the angle-calculation stage into a hobby-servo PWM waveform for the robotic-arm joint. Captures `angle_data` on the rising edge of `angle_gen_flag` and clamps it to the servo range. Moves the commanded position toward the target at a bounded rate, one step per PWM period. Drives a glitch-free PWM output whose pulse width is latched only at period boundaries.

## Interface
Parameters:
- PERIOD_CYC, 1_000_000: clk cycles per PWM period (20 ms at 50 MHz).
- PULSE_MIN_CYC, 25_000: pulse width at 0° (0.5 ms).
- CYC_PER_DEG, 556: extra pulse cycles per degree.
- ANGLE_MAX, 180: largest commandable angle, in degrees.
- STEP_DEG, 2: maximum change of the current angle per period.
- INIT_ANGLE, 90: current and target angle after reset.

Ports:
- clk: input, 1 bit. System clock.
- rst_n: input, 1 bit. Asynchronous, active-low reset.
- angle_data: input, 10 bits. Requested angle, unsigned; bit 9 set means a wrapped negative value.
- angle_gen_flag: input, 1 bit. Angle-valid strobe, level or pulse.
- en: input, 1 bit. Output enable.
- pwm_out: output, 1 bit. Servo PWM, registered.
- cur_angle: output, 8 bits. Angle currently being driven.
- busy: output, 1 bit. High while cur_angle ≠ target.
- done: output, 1 bit. One-cycle pulse when cur_angle reaches target.

## Operation
- **Capture:**
  - Register `angle_gen_flag` (flag_d).
  - A new target loads only when `angle_gen_flag && !flag_d`. A flag held high for many cycles captures once.
- **Clamp at capture:**
  - angle_data[9] = 1 → target = 0.
  - angle_data > ANGLE_MAX → target = ANGLE_MAX.
  - Otherwise target = angle_data[7:0].
- **Period counter:** cnt runs 0 … PERIOD_CYC−1, then wraps to 0. It runs continuously, independent of `en`.
- **Ramp FSM, states HOLD and RAMP:**
  - HOLD: cur_angle == target, busy = 0.
  - A capture with a differing target → RAMP.
  - In RAMP, at cnt == PERIOD_CYC/2, cur_angle moves toward target by min(STEP_DEG, |target − cur_angle|).
  - When cur_angle equals target after that update → HOLD, and `done` pulses for 1 cycle.
- **Retarget mid-ramp:** a capture during RAMP replaces target. cur_angle continues from its present value, with no jump. A retarget equal to cur_angle → HOLD immediately, with no `done` pulse.
- **Capture during the update cycle:** if a capture coincides with the update cycle, the update uses the old target and the new target takes effect from the next cycle.
- **Width computation:**
  - width_r ← PULSE_MIN_CYC + cur_angle × CYC_PER_DEG, registered every cycle.
  - Width is at least 20 bits; the product is computed at full width with no truncation.
- **Pulse latch:** at cnt == PERIOD_CYC−1, pulse_len ← width_r. The pulse width never changes inside a period.
- **Output:** pwm_out ← en && (cnt < pulse_len), registered.
- **Disable:** `en` low forces pwm_out low on the next cycle. Ramping continues while disabled.

## Timing
- **Reset values:**
  - cnt = 0, flag_d = 0.
  - target = cur_angle = INIT_ANGLE.
  - pulse_len = PULSE_MIN_CYC + INIT_ANGLE × CYC_PER_DEG.
  - pwm_out = 0, busy = 0, done = 0.
- **First pulse after reset:** rst_n deassert → pwm_out rises on the first clk edge where en = 1.
- **Capture latency:** edge of angle_gen_flag → target updated next cycle. busy rises in that same cycle if target ≠ cur_angle.
- **Width to output latency:**
  - A cur_angle update at mid-period appears in width_r 1 cycle later.
  - It takes effect on pwm_out in the next period.
  - Worst case from capture to first changed pulse is 1.5 periods.
- **Ramp time:** a ramp of D degrees takes ceil(D / STEP_DEG) periods.
- **done timing:** `done` asserts in the cycle after the final update, which is the cycle busy falls.
- **Reset mid-operation:** everything returns to the reset values above. An in-progress pulse is truncated.

## Test plan
All scenarios use PERIOD_CYC = 1000, PULSE_MIN_CYC = 50, CYC_PER_DEG = 2, STEP_DEG = 10, INIT_ANGLE = 90, en = 1.
- **Reset:** release reset → pwm_out high for 230 cycles per 1000-cycle period; busy = 0, cur_angle = 90.
- **Ramp up:** angle_data = 120, 1-cycle flag → busy rises; cur_angle reads 100, 110, 120 at three successive mid-periods; one done pulse; final pulse width 290.
- **Clamp:** angle_data = 10'h3D3 (negative) → target 0, ramp ends at width 50. angle_data = 250 → target 180, final width 410.
- **Retarget:** retarget to 60 while ramping from 90 toward 150 (cur_angle = 110) → cur_angle steps 100, 90, 80, 70, 60; exactly one done pulse.
- **Held flag:** flag held high for 3000 cycles with angle_data changing → only the value at the rising edge is captured.
- **Enable and wrap:** en low for 2 periods → pwm_out = 0 throughout while cur_angle still ramps. Also check wrap: no pulse-width change occurs mid-period (width is constant within each period).
